lut_config_loader: RTL and testbench



---
 rtl/lut_config_loader.sv | 133 +++++++++++++
 tb/tb_lut_config_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/lut_config_loader.sv
// lut_config_loader: streams host words into a daisy-chained LUT config scan chain
// and rotates the chain non-destructively to read it back as words.
module lut_config_loader #(
    parameter int NUM_LUTS    = 4,
    parameter int MEM_SIZE    = 16,
    parameter int FRAME_WIDTH = 1,
    parameter int WORD_WIDTH  = 8
) (
    input  logic                   config_clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   mode,
    input  logic                   word_valid,
    input  logic [WORD_WIDTH-1:0]  word_data,
    output logic                   word_ready,
    output logic                   rd_valid,
    output logic [WORD_WIDTH-1:0]  rd_data,
    input  logic                   rd_ready,
    output logic                   chain_config_en,
    output logic [FRAME_WIDTH-1:0] chain_config_in,
    input  logic [FRAME_WIDTH-1:0] chain_config_out,
    output logic                   busy,
    output logic                   done
);
    localparam int FPW         = WORD_WIDTH / FRAME_WIDTH;
    localparam int TOTAL_WORDS = NUM_LUTS * MEM_SIZE / WORD_WIDTH;
    localparam int KW          = FPW > 1 ? $clog2(FPW) : 1;
    localparam int WC          = TOTAL_WORDS > 1 ? $clog2(TOTAL_WORDS) : 1;

    typedef enum logic [2:0] {IDLE, LD_WAIT, LD_SHIFT, RB_SHIFT, RB_HOLD, DONE} state_t;

    state_t                  state;
    logic [KW-1:0]           k;
    logic [WC-1:0]           w;
    logic [WORD_WIDTH-1:0]   sreg;
    logic                    ph;
    logic                    last_k;
    logic                    last_w;

    assign last_k = k == KW'(FPW - 1);
    assign last_w = w == WC'(TOTAL_WORDS - 1);

    // Readback alternates a sample phase (ph=0) with a shift phase (ph=1) so the
    // registered chain_config_in always carries the frame that is leaving the tail.
    always_ff @(posedge config_clk) begin
        if (reset) begin
            state           <= IDLE;
            k               <= '0;
            w               <= '0;
            sreg            <= '0;
            ph              <= 1'b0;
            word_ready      <= 1'b0;
            rd_valid        <= 1'b0;
            rd_data         <= '0;
            chain_config_en <= 1'b0;
            chain_config_in <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    k  <= '0;
                    w  <= '0;
                    ph <= 1'b0;
                    if (start) begin
                        busy       <= 1'b1;
                        word_ready <= !mode;
                        state      <= mode ? RB_SHIFT : LD_WAIT;
                    end
                end
                LD_WAIT: if (word_valid) begin
                    word_ready      <= 1'b0;
                    sreg            <= word_data >> FRAME_WIDTH;
                    chain_config_in <= word_data[FRAME_WIDTH-1:0];
                    chain_config_en <= 1'b1;
                    k               <= '0;
                    state           <= LD_SHIFT;
                end
                LD_SHIFT: if (last_k) begin
                    chain_config_en <= 1'b0;
                    chain_config_in <= '0;
                    k               <= '0;
                    if (last_w) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        w          <= w + 1'b1;
                        word_ready <= 1'b1;
                        state      <= LD_WAIT;
                    end
                end else begin
                    k               <= k + 1'b1;
                    chain_config_in <= sreg[FRAME_WIDTH-1:0];
                    sreg            <= sreg >> FRAME_WIDTH;
                end
                RB_SHIFT: if (!ph) begin
                    ph              <= 1'b1;
                    chain_config_en <= 1'b1;
                    chain_config_in <= chain_config_out;
                end else begin
                    ph              <= 1'b0;
                    chain_config_en <= 1'b0;
                    chain_config_in <= '0;
                    // frame 0 of each returned word sits at its top
                    rd_data[(FPW - 1 - int'(k)) * FRAME_WIDTH +: FRAME_WIDTH] <= chain_config_out;
                    if (last_k) begin
                        k        <= '0;
                        rd_valid <= 1'b1;
                        state    <= RB_HOLD;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                RB_HOLD: if (rd_ready) begin
                    rd_valid <= 1'b0;
                    if (last_w) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        w     <= w + 1'b1;
                        state <= RB_SHIFT;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lut_config_loader.sv
// tb_lut_config_loader: drives loads/readbacks on a 2-LUT x 4-bit chain model
// and checks shifted frames, LUT contents, readback words and handshake timing.
module tb_lut_config_loader;
    logic       config_clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic       word_valid = 1'b0;
    logic [3:0] word_data = '0;
    logic       word_ready;
    logic       rd_valid;
    logic [3:0] rd_data;
    logic       rd_ready = 1'b0;
    logic       chain_config_en;
    logic [0:0] chain_config_in;
    logic [0:0] chain_config_out;
    logic       busy;
    logic       done;

    // chain[7:4] = LUT0 (head), chain[3:0] = LUT1 (tail); each LUT shifts toward bit 0
    logic [7:0] chain = '0;
    logic [7:0] seq = '0;
    int         en_cnt = 0, done_cnt = 0, rdv_cnt = 0, cyc = 0;
    int         checks = 0, errors = 0;

    lut_config_loader #(.NUM_LUTS(2), .MEM_SIZE(4), .FRAME_WIDTH(1), .WORD_WIDTH(4)) dut (
        .config_clk(config_clk), .reset(reset), .start(start), .mode(mode),
        .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .chain_config_en(chain_config_en), .chain_config_in(chain_config_in),
        .chain_config_out(chain_config_out), .busy(busy), .done(done)
    );

    always #5 config_clk = ~config_clk;

    assign chain_config_out = chain[0];

    always @(posedge config_clk) begin
        cyc = cyc + 1;
        if (chain_config_en) begin
            chain <= {chain_config_in, chain[7:1]};
            if (en_cnt < 8) seq[en_cnt] = chain_config_in[0];
            en_cnt = en_cnt + 1;
        end
        if (done) done_cnt = done_cnt + 1;
        if (rd_valid) rdv_cnt = rdv_cnt + 1;
    end

    typedef struct {
        logic       rb;
        logic [3:0] w0, w1;
        int         gap;
        int         stall;
        logic [7:0] seq;
        logic [3:0] l0, l1, r0, r1;
    } vec_t;

    vec_t tv[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_for(input int sel, input string nm);
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge config_clk);
            if ((sel == 0 && word_ready) || (sel == 1 && rd_valid) || (sel == 2 && done)) break;
        end
        if (i == 100) begin
            checks++;
            errors++;
            $display("FAIL timeout waiting for %s", nm);
        end
    endtask

    task automatic reset_outputs(input string nm);
        chk({nm, "_word_ready"}, word_ready, 0);
        chk({nm, "_rd_valid"}, rd_valid, 0);
        chk({nm, "_rd_data"}, rd_data, 0);
        chk({nm, "_en"}, chain_config_en, 0);
        chk({nm, "_cfg_in"}, chain_config_in, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
    endtask

    task automatic run_op(input vec_t v);
        int t0;
        en_cnt = 0; done_cnt = 0; rdv_cnt = 0; seq = '0;
        start = 1'b1;
        mode = v.rb;
        rd_ready = v.rb && v.stall == 0;
        @(posedge config_clk); #1;
        start = 1'b0;
        mode = 1'b0;
        t0 = cyc;
        if (!v.rb) begin
            word_valid = 1'b1;
            word_data = v.w0;
            wait_for(0, "word_ready w0");
            @(posedge config_clk); #1;
            if (v.gap > 0) begin
                word_valid = 1'b0;
                wait_for(0, "word_ready gap");
                for (int j = 0; j < v.gap; j++) begin
                    if (j == 0) begin start = 1'b1; mode = 1'b1; end
                    chk("gap_word_ready", word_ready, 1);
                    chk("gap_en", chain_config_en, 0);
                    @(negedge config_clk);
                    start = 1'b0;
                    mode = 1'b0;
                end
                word_valid = 1'b1;
                word_data = v.w1;
                @(posedge config_clk); #1;
            end else begin
                word_data = v.w1;
                wait_for(0, "word_ready w1");
                @(posedge config_clk); #1;
            end
            word_valid = 1'b0;
            wait_for(2, "load done");
            if (v.gap == 0) chk("load_latency", cyc - t0, 10);
        end else begin
            wait_for(1, "rd_valid w0");
            chk("rd_word0", rd_data, v.r0);
            for (int j = 0; j < v.stall; j++) begin
                @(negedge config_clk);
                chk("stall_rd_valid", rd_valid, 1);
                chk("stall_rd_data", rd_data, v.r0);
                chk("stall_en", chain_config_en, 0);
            end
            if (v.stall > 0) chk("stall_en_cnt", en_cnt, 4);
            rd_ready = 1'b1;
            @(posedge config_clk); #1;
            wait_for(1, "rd_valid w1");
            chk("rd_word1", rd_data, v.r1);
            @(posedge config_clk); #1;
            rd_ready = 1'b0;
            wait_for(2, "readback done");
        end
        @(posedge config_clk); #1;
        chk("en_cycles", en_cnt, 8);
        chk("frame_seq", seq, v.seq);
        chk("done_pulses", done_cnt, 1);
        chk("lut0_mem", chain[7:4], v.l0);
        chk("lut1_mem", chain[3:0], v.l1);
        chk("busy_after", busy, 0);
        if (!v.rb) chk("no_readback", rdv_cnt, 0);
    endtask

    initial begin
        tv[0] = '{rb: 0, w0: 4'hA, w1: 4'h5, gap: 0, stall: 0, seq: 8'h5A, l0: 4'h5, l1: 4'hA, r0: 0, r1: 0};
        tv[1] = '{rb: 1, w0: 0, w1: 0, gap: 0, stall: 0, seq: 8'h5A, l0: 4'h5, l1: 4'hA, r0: 4'h5, r1: 4'hA};
        tv[2] = '{rb: 1, w0: 0, w1: 0, gap: 0, stall: 5, seq: 8'h5A, l0: 4'h5, l1: 4'hA, r0: 4'h5, r1: 4'hA};
        tv[3] = '{rb: 0, w0: 4'h3, w1: 4'hC, gap: 0, stall: 0, seq: 8'hC3, l0: 4'hC, l1: 4'h3, r0: 0, r1: 0};
        tv[4] = '{rb: 0, w0: 4'hA, w1: 4'h5, gap: 3, stall: 0, seq: 8'h5A, l0: 4'h5, l1: 4'hA, r0: 0, r1: 0};
        tv[5] = '{rb: 0, w0: 4'h3, w1: 4'hC, gap: 0, stall: 0, seq: 8'hC3, l0: 4'hC, l1: 4'h3, r0: 0, r1: 0};
        tv[6] = '{rb: 1, w0: 0, w1: 0, gap: 0, stall: 0, seq: 8'hC3, l0: 4'hC, l1: 4'h3, r0: 4'hC, r1: 4'h3};

        repeat (3) @(posedge config_clk);
        @(negedge config_clk);
        reset_outputs("reset");
        reset = 1'b0;
        @(negedge config_clk);

        for (int i = 0; i < 7; i++) begin
            if (i == 5) begin
                // abort a load after three shifts
                en_cnt = 0;
                start = 1'b1;
                @(posedge config_clk); #1;
                start = 1'b0;
                word_valid = 1'b1;
                word_data = 4'h6;
                wait_for(0, "word_ready abort");
                @(posedge config_clk); #1;
                repeat (3) @(posedge config_clk);
                #1;
                chk("abort_shifts", en_cnt, 3);
                chk("abort_busy_before", busy, 1);
                reset = 1'b1;
                @(posedge config_clk); #1;
                reset_outputs("abort");
                reset = 1'b0;
                word_valid = 1'b0;
                @(negedge config_clk);
            end
            run_op(tv[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
